// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one Memory port between the instruction-miss path
// (read-only) and the data path (read/write). One transaction in flight,
// round-robin on contention, watchdog abort when Memory never answers.
module memory_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_read_request,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_read_response,
    output logic [DATA_WIDTH-1:0] i_read_data,
    input  logic                  d_read_request,
    input  logic                  d_write_request,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_write_data,
    output logic                  d_response,
    output logic [DATA_WIDTH-1:0] d_read_data,
    output logic                  memory_read_request,
    output logic                  memory_write_request,
    output logic [ADDR_WIDTH-1:0] memory_addr,
    output logic [DATA_WIDTH-1:0] memory_write_data,
    input  logic [DATA_WIDTH-1:0] memory_read_data,
    input  logic                  memory_response,
    output logic                  busy,
    output logic                  timeout_error
);

    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          WDOG_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_last_grant_i;
    logic                  r_mem_rd;
    logic                  r_mem_wr;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [CNT_W-1:0]      r_count;
    logic                  r_busy;

    state_t                w_state_nx;
    logic                  w_last_grant_i_nx;
    logic                  w_mem_rd_nx;
    logic                  w_mem_wr_nx;
    logic [ADDR_WIDTH-1:0] w_mem_addr_nx;
    logic [DATA_WIDTH-1:0] w_mem_wdata_nx;
    logic [CNT_W-1:0]      w_count_nx;
    logic                  w_busy_nx;

    logic                  w_granted;
    logic                  w_owner_i;
    logic                  w_owner_d;
    logic                  w_done;
    logic                  w_expire;
    logic                  w_finish;
    logic                  w_d_req;

    // Completion decode: a response in reset or in IDLE is never forwarded
    assign w_granted = (r_state != ST_IDLE) && !reset;
    assign w_owner_i = (r_state == ST_GRANT_I);
    assign w_owner_d = (r_state == ST_GRANT_D);
    assign w_done    = w_granted && memory_response;
    assign w_expire  = WDOG_EN && w_granted && !memory_response &&
                       (r_count == CNT_W'(TIMEOUT_CYCLES));
    assign w_finish  = w_done || w_expire;
    assign w_d_req   = d_read_request || d_write_request;

    // Next-state and next-register values
    always_comb begin
        w_state_nx        = r_state;
        w_last_grant_i_nx = r_last_grant_i;
        w_mem_rd_nx       = r_mem_rd;
        w_mem_wr_nx       = r_mem_wr;
        w_mem_addr_nx     = r_mem_addr;
        w_mem_wdata_nx    = r_mem_wdata;
        w_count_nx        = r_count;
        w_busy_nx         = r_busy;
        case (r_state)
            ST_IDLE: begin
                if (w_d_req && (!i_read_request || r_last_grant_i)) begin
                    w_state_nx        = ST_GRANT_D;
                    w_last_grant_i_nx = 1'b0;
                    w_mem_wr_nx       = d_write_request;
                    w_mem_rd_nx       = !d_write_request;
                    w_mem_addr_nx     = d_addr;
                    w_mem_wdata_nx    = d_write_data;
                    w_count_nx        = '0;
                    w_busy_nx         = 1'b1;
                end else if (i_read_request) begin
                    w_state_nx        = ST_GRANT_I;
                    w_last_grant_i_nx = 1'b1;
                    w_mem_wr_nx       = 1'b0;
                    w_mem_rd_nx       = 1'b1;
                    w_mem_addr_nx     = i_addr;
                    w_mem_wdata_nx    = '0;
                    w_count_nx        = '0;
                    w_busy_nx         = 1'b1;
                end
            end
            ST_GRANT_I, ST_GRANT_D: begin
                if (w_finish) begin
                    w_state_nx  = ST_IDLE;
                    w_mem_rd_nx = 1'b0;
                    w_mem_wr_nx = 1'b0;
                    w_count_nx  = '0;
                    w_busy_nx   = 1'b0;
                end else begin
                    w_count_nx  = r_count + CNT_W'(1);
                end
            end
            default: begin
                w_state_nx  = ST_IDLE;
                w_mem_rd_nx = 1'b0;
                w_mem_wr_nx = 1'b0;
                w_busy_nx   = 1'b0;
            end
        endcase
    end

    // State and Memory-side registers; reset drops strobes immediately
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_last_grant_i <= 1'b1;
            r_mem_rd       <= 1'b0;
            r_mem_wr       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_count        <= '0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_last_grant_i <= w_last_grant_i_nx;
            r_mem_rd       <= w_mem_rd_nx;
            r_mem_wr       <= w_mem_wr_nx;
            r_mem_addr     <= w_mem_addr_nx;
            r_mem_wdata    <= w_mem_wdata_nx;
            r_count        <= w_count_nx;
            r_busy         <= w_busy_nx;
        end
    end

    assign memory_read_request  = r_mem_rd;
    assign memory_write_request = r_mem_wr;
    assign memory_addr          = r_mem_addr;
    assign memory_write_data    = r_mem_wdata;
    assign busy                 = r_busy;

    // Responses pass through in the memory_response cycle; abort zeroes data
    assign i_read_response = w_owner_i && w_finish;
    assign d_response      = w_owner_d && w_finish;
    assign timeout_error   = w_expire;
    assign i_read_data     = (w_owner_i && w_expire) ? '0 : memory_read_data;
    assign d_read_data     = (w_owner_d && w_expire) ? '0 : memory_read_data;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a small behavioural Memory model.
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_read_request;
    logic [31:0] i_addr;
    logic        i_read_response;
    logic [31:0] i_read_data;
    logic        d_read_request;
    logic        d_write_request;
    logic [31:0] d_addr;
    logic [31:0] d_write_data;
    logic        d_response;
    logic [31:0] d_read_data;
    logic        memory_read_request;
    logic        memory_write_request;
    logic [31:0] memory_addr;
    logic [31:0] memory_write_data;
    logic [31:0] memory_read_data;
    logic        memory_response;
    logic        busy;
    logic        timeout_error;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    memory_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .i_read_request      (i_read_request),
        .i_addr              (i_addr),
        .i_read_response     (i_read_response),
        .i_read_data         (i_read_data),
        .d_read_request      (d_read_request),
        .d_write_request     (d_write_request),
        .d_addr              (d_addr),
        .d_write_data        (d_write_data),
        .d_response          (d_response),
        .d_read_data         (d_read_data),
        .memory_read_request (memory_read_request),
        .memory_write_request(memory_write_request),
        .memory_addr         (memory_addr),
        .memory_write_data   (memory_write_data),
        .memory_read_data    (memory_read_data),
        .memory_response     (memory_response),
        .busy                (busy),
        .timeout_error       (timeout_error)
    );

    // Memory model: answers after mem_lat strobe cycles when mem_en is set
    logic [31:0] mem [256];
    logic        mem_resp = 1'b0;
    logic [31:0] mem_rdata = 32'h5555_AAAA;
    logic        stray;
    bit          mem_en;
    int          mem_lat;
    int          mem_cnt = 0;

    assign memory_response  = mem_resp | stray;
    assign memory_read_data = mem_rdata;

    initial begin
        mem[0]  <= 32'hA5A5_0000;
        mem[1]  <= 32'h0000_0013;
        mem[64] <= 32'hCAFE_0100;
    end

    always @(posedge clk) begin
        if (mem_resp) begin
            mem_resp  <= 1'b0;
            mem_cnt   <= 0;
            mem_rdata <= 32'h5555_AAAA;
        end else if ((memory_read_request || memory_write_request) && mem_en) begin
            if (mem_cnt == mem_lat - 1) begin
                mem_resp <= 1'b1;
                mem_cnt  <= 0;
                if (memory_write_request) begin
                    mem[memory_addr[9:2]] <= memory_write_data;
                    mem_rdata <= 32'h0;
                end else begin
                    mem_rdata <= mem[memory_addr[9:2]];
                end
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string pfx);
        check({pfx, "_rd_strobe"}, 32'(memory_read_request), 32'h0);
        check({pfx, "_wr_strobe"}, 32'(memory_write_request), 32'h0);
        check({pfx, "_addr"}, memory_addr, 32'h0);
        check({pfx, "_wdata"}, memory_write_data, 32'h0);
        check({pfx, "_busy"}, 32'(busy), 32'h0);
        check({pfx, "_i_resp"}, 32'(i_read_response), 32'h0);
        check({pfx, "_d_resp"}, 32'(d_response), 32'h0);
        check({pfx, "_tmo"}, 32'(timeout_error), 32'h0);
    endtask

    // Called at the negedge of grant cycle 1; returns in the response cycle
    task automatic wait_resp(input bit side_d, output int cyc, output logic [31:0] data);
        bit seen = 1'b0;
        cyc  = 0;
        data = '0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            check("strobe_excl", 32'(memory_read_request & memory_write_request), 32'h0);
            check("resp_excl", 32'(i_read_response & d_response), 32'h0);
            if ((side_d ? d_response : i_read_response) === 1'b1) begin
                seen = 1'b1;
                cyc  = n;
                data = side_d ? d_read_data : i_read_data;
            end else begin
                @(negedge clk);
            end
        end
        check("resp_seen", 32'(seen), 32'h1);
    endtask

    int          cyc;
    logic [31:0] data;

    initial begin
        reset = 1'b1;
        i_read_request = 1'b0; i_addr = '0;
        d_read_request = 1'b0; d_write_request = 1'b0;
        d_addr = '0; d_write_data = '0;
        stray = 1'b0; mem_en = 1'b1; mem_lat = 2;
        repeat (2) @(negedge clk);
        check_idle("rst");
        reset = 1'b0;

        // Single I read of 0x4
        i_read_request = 1'b1; i_addr = 32'h4;
        @(negedge clk);
        check("t1_rd_strobe", 32'(memory_read_request), 32'h1);
        check("t1_wr_strobe", 32'(memory_write_request), 32'h0);
        check("t1_addr", memory_addr, 32'h4);
        check("t1_busy", 32'(busy), 32'h1);
        i_read_request = 1'b0;
        wait_resp(1'b0, cyc, data);
        check("t1_lat", 32'(cyc), 32'd3);
        check("t1_data", data, 32'h0000_0013);
        check("t1_tmo", 32'(timeout_error), 32'h0);
        check("t1_d_resp", 32'(d_response), 32'h0);
        @(negedge clk);
        check("t1_busy_fall", 32'(busy), 32'h0);
        check("t1_strobe_fall", 32'(memory_read_request), 32'h0);
        check("t1_one_pulse", 32'(i_read_response), 32'h0);

        // Stray memory_response while idle is ignored
        stray = 1'b1;
        #1;
        check("stray_i", 32'(i_read_response), 32'h0);
        check("stray_d", 32'(d_response), 32'h0);
        @(negedge clk);
        stray = 1'b0;
        check("stray_busy", 32'(busy), 32'h0);

        // Contention right after reset: D first, then I
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        i_read_request = 1'b1; i_addr = 32'h0;
        d_read_request = 1'b1; d_addr = 32'h100;
        @(negedge clk);
        check("t2_first_addr", memory_addr, 32'h100);
        check("t2_first_rd", 32'(memory_read_request), 32'h1);
        d_read_request = 1'b0;
        wait_resp(1'b1, cyc, data);
        check("t2_d_data", data, 32'hCAFE_0100);
        @(negedge clk);
        check("t2_turn", 32'(busy), 32'h0);
        @(negedge clk);
        check("t2_second_busy", 32'(busy), 32'h1);
        check("t2_second_addr", memory_addr, 32'h0);
        i_read_request = 1'b0;
        wait_resp(1'b0, cyc, data);
        check("t2_i_data", data, 32'hA5A5_0000);
        @(negedge clk);

        // Both held: strict D,I alternation with 1-cycle turnaround
        i_read_request = 1'b1; i_addr = 32'h4;
        d_read_request = 1'b1; d_addr = 32'h100;
        @(negedge clk);
        for (int t = 0; t < 6; t++) begin
            check("t3_addr", memory_addr, (t % 2 == 0) ? 32'h100 : 32'h4);
            if (t == 5) begin
                i_read_request = 1'b0;
                d_read_request = 1'b0;
            end
            wait_resp((t % 2 == 0), cyc, data);
            check("t3_data", data, (t % 2 == 0) ? 32'hCAFE_0100 : 32'h0000_0013);
            @(negedge clk);
            check("t3_turn", 32'(busy), 32'h0);
            @(negedge clk);
            check("t3_regrant", 32'(busy), (t < 5) ? 32'h1 : 32'h0);
        end

        // D write then read-back; inputs change during grant without effect
        mem_lat = 3;
        d_write_request = 1'b1; d_addr = 32'h200; d_write_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t4_wr_strobe", 32'(memory_write_request), 32'h1);
        check("t4_rd_strobe", 32'(memory_read_request), 32'h0);
        check("t4_addr", memory_addr, 32'h200);
        check("t4_wdata", memory_write_data, 32'hDEAD_BEEF);
        d_write_request = 1'b0; d_addr = 32'h3FC; d_write_data = 32'h0;
        wait_resp(1'b1, cyc, data);
        check("t4_wr_lat", 32'(cyc), 32'd4);
        check("t4_addr_hold", memory_addr, 32'h200);
        check("t4_wdata_hold", memory_write_data, 32'hDEAD_BEEF);
        @(negedge clk);
        check("t4_wr_fall", 32'(memory_write_request), 32'h0);
        d_read_request = 1'b1; d_addr = 32'h200;
        @(negedge clk);
        check("t4_rd_strobe2", 32'(memory_read_request), 32'h1);
        d_read_request = 1'b0;
        wait_resp(1'b1, cyc, data);
        check("t4_readback", data, 32'hDEAD_BEEF);
        @(negedge clk);
        d_read_request = 1'b1; d_write_request = 1'b1;
        d_addr = 32'h204; d_write_data = 32'h1234_5678;
        @(negedge clk);
        check("t4_both_wr", 32'(memory_write_request), 32'h1);
        check("t4_both_rd", 32'(memory_read_request), 32'h0);
        d_read_request = 1'b0; d_write_request = 1'b0;
        wait_resp(1'b1, cyc, data);
        @(negedge clk);

        // Watchdog: no Memory response, abort after 8 waiting cycles
        mem_en = 1'b0;
        i_read_request = 1'b1; i_addr = 32'h4;
        @(negedge clk);
        i_read_request = 1'b0;
        wait_resp(1'b0, cyc, data);
        check("t5_tmo_cycle", 32'(cyc), 32'd9);
        check("t5_tmo_err", 32'(timeout_error), 32'h1);
        check("t5_tmo_data", data, 32'h0);
        @(negedge clk);
        check("t5_strobe_fall", 32'(memory_read_request), 32'h0);
        check("t5_err_pulse", 32'(timeout_error), 32'h0);
        check("t5_busy_fall", 32'(busy), 32'h0);

        // Response landing in the exact timeout cycle completes normally
        mem_en = 1'b1; mem_lat = 8;
        d_read_request = 1'b1; d_addr = 32'h100;
        @(negedge clk);
        d_read_request = 1'b0;
        wait_resp(1'b1, cyc, data);
        check("t5b_cycle", 32'(cyc), 32'd9);
        check("t5b_no_err", 32'(timeout_error), 32'h0);
        check("t5b_data", data, 32'hCAFE_0100);
        @(negedge clk);

        // Reset mid-grant (D read pending); last grant restored to I
        mem_en = 1'b0; mem_lat = 2;
        d_read_request = 1'b1; d_addr = 32'h100;
        @(negedge clk);
        check("t6_busy", 32'(busy), 32'h1);
        d_read_request = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t6_no_resp", 32'(d_response), 32'h0);
        @(negedge clk);
        check_idle("t6");
        reset = 1'b0; mem_en = 1'b1;
        i_read_request = 1'b1; i_addr = 32'h4;
        d_read_request = 1'b1; d_addr = 32'h100;
        @(negedge clk);
        check("t6_d_first", memory_addr, 32'h100);
        i_read_request = 1'b0; d_read_request = 1'b0;
        wait_resp(1'b1, cyc, data);
        check("t6_data", data, 32'hCAFE_0100);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
